// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit for the HI/LO write path.
// Multiplies with shift-add (LSB first); divides with restoring shift-subtract (MSB first).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// RUN     | one multiply/divide iteration per clock, 32 in total
// FIX     | apply result/remainder signs, write lo/hi (or divide-by-zero result)
// DONE    | done pulse; a new start is accepted here as well
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             div_by_zero
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               res_neg_q, res_neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic               div_by_zero_q, div_by_zero_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // op[0] clear selects the signed flavour of both MULT and DIV
   assign a_mag = (!op[0] && a[WIDTH-1]) ? ('0 - a) : a;
   assign b_mag = (!op[0] && b[WIDTH-1]) ? ('0 - b) : b;

   // acc = {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};

   assign prod_fix = res_neg_q ? ('0 - acc_q) : acc_q;
   assign quo_fix  = res_neg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
   assign rem_fix  = rem_neg_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      mcand_d       = mcand_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      res_neg_d     = res_neg_q;
      rem_neg_d     = rem_neg_q;
      dz_d          = dz_q;
      lo_d          = lo_q;
      hi_d          = hi_q;
      div_by_zero_d = div_by_zero_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               op_d          = op;
               res_neg_d     = !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
               rem_neg_d     = !op[0] && a[WIDTH-1];
               cnt_d         = '0;
               div_by_zero_d = 1'b0;
               mcand_d       = op[1] ? b_mag : a_mag;
               if (op[1] && (b == '0)) begin
                  // Divide-by-zero result is staged in acc so FIX just copies it out
                  dz_d    = 1'b1;
                  acc_d   = {a, {WIDTH{1'b1}}};
                  state_d = ST_FIX;
               end else begin
                  dz_d    = 1'b0;
                  acc_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                  state_d = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (op_q[1]) begin
               if (!div_diff[WIDTH])
                  acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1))
               state_d = ST_FIX;
         end

         ST_FIX: begin
            if (dz_q) begin
               lo_d = acc_q[WIDTH-1:0];
               hi_d = acc_q[2*WIDTH-1:WIDTH];
            end else if (op_q[1]) begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end else begin
               lo_d = prod_fix[WIDTH-1:0];
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
            end
            div_by_zero_d = dz_q;
            state_d       = ST_DONE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         mcand_q       <= '0;
         acc_q         <= '0;
         cnt_q         <= '0;
         res_neg_q     <= 1'b0;
         rem_neg_q     <= 1'b0;
         dz_q          <= 1'b0;
         lo_q          <= '0;
         hi_q          <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         mcand_q       <= mcand_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         res_neg_q     <= res_neg_d;
         rem_neg_q     <= rem_neg_d;
         dz_q          <= dz_d;
         lo_q          <= lo_d;
         hi_q          <= hi_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
   assign done        = (state_q == ST_DONE);
   assign lo          = lo_q;
   assign hi          = hi_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, signed/unsigned results, divide-by-zero,
// ignored mid-operation starts, back-to-back starts and asynchronous reset.
module tb_mul_div_unit;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] lo, hi;

   int vectors = 0;
   int miscompares = 0;

   mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .lo(lo), .hi(hi), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Launch one operation and wait (bounded) for done; returns edges to done and busy samples.
   task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output int cycles, output int busy_cnt);
      @(negedge clk);
      op = o; a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycles = 0; busy_cnt = 0;
      while (!done && cycles < 100) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({busy, done, div_by_zero, lo, hi} !== 67'd0) begin
         miscompares++;
         $display("FAIL reset_state: busy=%b done=%b dz=%b lo=%h hi=%h, required all 0",
                  busy, done, div_by_zero, lo, hi);
      end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_multu_latency;
      int cyc, bc;
      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bc);
      vectors++;
      if (cyc !== 33) begin
         miscompares++; $display("FAIL multu_latency: got %0d required 33", cyc);
      end
      vectors++;
      if (bc !== 33) begin
         miscompares++; $display("FAIL multu_busy_cycles: got %0d required 33", bc);
      end
      vectors++;
      if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
         miscompares++; $display("FAIL multu_max: hi=%h lo=%h required fffffffe 00000001", hi, lo);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL done_pulse_width: done=%b busy=%b required 0 0", done, busy);
      end
      vectors++;
      if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
         miscompares++; $display("FAIL result_hold: hi=%h lo=%h required fffffffe 00000001", hi, lo);
      end
   endtask

   task automatic test_mult_signed;
      int cyc, bc;
      run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, cyc, bc);
      vectors++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB || cyc !== 33) begin
         miscompares++; $display("FAIL mult_neg3x7: hi=%h lo=%h cyc=%0d required ffffffff ffffffeb 33", hi, lo, cyc);
      end
      run_op(OP_MULT, 32'h80000000, 32'h80000000, cyc, bc);
      vectors++;
      if (hi !== 32'h40000000 || lo !== 32'h0) begin
         miscompares++; $display("FAIL mult_minxmin: hi=%h lo=%h required 40000000 00000000", hi, lo);
      end
   endtask

   task automatic test_div;
      int cyc, bc;
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, cyc, bc);
      vectors++;
      if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || cyc !== 33) begin
         miscompares++; $display("FAIL div_neg7by2: lo=%h hi=%h cyc=%0d required fffffffd ffffffff 33", lo, hi, cyc);
      end
      run_op(OP_DIVU, 32'd100, 32'd7, cyc, bc);
      vectors++;
      if (lo !== 32'd14 || hi !== 32'd2 || div_by_zero !== 1'b0) begin
         miscompares++; $display("FAIL divu_100by7: lo=%0d hi=%0d dz=%b required 14 2 0", lo, hi, div_by_zero);
      end
      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, bc);
      vectors++;
      if (lo !== 32'h80000000 || hi !== 32'h0 || div_by_zero !== 1'b0) begin
         miscompares++; $display("FAIL div_min_by_m1: lo=%h hi=%h dz=%b required 80000000 0 0", lo, hi, div_by_zero);
      end
   endtask

   task automatic test_div_by_zero;
      int cyc, bc;
      run_op(OP_DIVU, 32'd100, 32'd0, cyc, bc);
      vectors++;
      if (cyc !== 1 || div_by_zero !== 1'b1 || lo !== 32'hFFFFFFFF || hi !== 32'd100) begin
         miscompares++;
         $display("FAIL divu_by_zero: cyc=%0d dz=%b lo=%h hi=%0d required 1 1 ffffffff 100", cyc, div_by_zero, lo, hi);
      end
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, cyc, bc);
      vectors++;
      if (cyc !== 1 || div_by_zero !== 1'b1 || lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin
         miscompares++;
         $display("FAIL div_by_zero_signed: cyc=%0d dz=%b lo=%h hi=%h required 1 1 ffffffff fffffff9", cyc, div_by_zero, lo, hi);
      end
      run_op(OP_DIVU, 32'd100, 32'd7, cyc, bc);
      vectors++;
      if (div_by_zero !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
         miscompares++; $display("FAIL dz_cleared: dz=%b lo=%0d hi=%0d required 0 14 2", div_by_zero, lo, hi);
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      logic lohi_changed;
      @(negedge clk);
      op = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      lohi_changed = 1'b0;
      while (!done && cyc < 100) begin
         if (cyc == 10) begin
            op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      vectors++;
      if (lo !== 32'd30 || hi !== 32'd0 || cyc !== 33) begin
         miscompares++; $display("FAIL start_while_busy: lo=%0d hi=%0d cyc=%0d required 30 0 33", lo, hi, cyc);
      end
      // Assert start during the DONE cycle itself
      op = OP_DIVU; a = 32'd30; b = 32'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 100) begin
         if (lo !== 32'd30 || hi !== 32'd0) lohi_changed = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      vectors++;
      if (lohi_changed !== 1'b0) begin
         miscompares++; $display("FAIL lohi_stable_while_busy: changed=%b required 0", lohi_changed);
      end
      vectors++;
      if (lo !== 32'd7 || hi !== 32'd2 || cyc !== 33) begin
         miscompares++; $display("FAIL back_to_back_divu: lo=%0d hi=%0d cyc=%0d required 7 2 33", lo, hi, cyc);
      end
   endtask

   task automatic test_reset_mid_op;
      int cyc, bc;
      logic saw_done;
      @(negedge clk);
      op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || lo !== 32'd0 || hi !== 32'd0 || done !== 1'b0) begin
         miscompares++; $display("FAIL reset_mid_op: busy=%b done=%b lo=%h hi=%h required 0 0 0 0", busy, done, lo, hi);
      end
      saw_done = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      @(negedge clk); reset = 1'b1;
      repeat (25) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      vectors++;
      if (saw_done !== 1'b0) begin
         miscompares++; $display("FAIL no_done_after_reset: saw_done=%b required 0", saw_done);
      end
      run_op(OP_MULTU, 32'd2, 32'd3, cyc, bc);
      vectors++;
      if (lo !== 32'd6 || hi !== 32'd0 || cyc !== 33) begin
         miscompares++; $display("FAIL mult_after_reset: lo=%0d hi=%0d cyc=%0d required 6 0 33", lo, hi, cyc);
      end
   endtask

   initial begin
      test_reset();
      test_multu_latency();
      test_mult_signed();
      test_div();
      test_div_by_zero();
      test_back_to_back();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit feeding the register bank's HI/LO write path.
- Operands come from the register bank read ports (D0/D1); results are written back as esc0 = lo and esc1 = hi during a mul/div register-write cycle.
- The control unit starts it, stalls on busy, and issues the HI/LO write when done pulses.

Parameters:
- WIDTH, 32, operand and result half-width; only 32 is required to be supported.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled on posedge clk.
- op  input  2  operation select: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- a  input  32  operand A: multiplicand or dividend.
- b  input  32  operand B: multiplier or divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when lo/hi become valid.
- lo  output  32  product[31:0] or quotient.
- hi  output  32  product[63:32] or remainder.
- div_by_zero  output  1  set on a DIV/DIVU with b == 0; valid with done.

Behaviour:
- Reset (async, reset = 0):
  - state = IDLE; busy = 0, done = 0, lo = 0, hi = 0, div_by_zero = 0, counter = 0.
  - Applies immediately, including mid-operation; the operation in progress is discarded and no done is produced.
- States: IDLE, RUN, FIX, DONE.
- IDLE or DONE, start = 1 at edge E0:
  - Latch op.
  - Latch |a| and |b| (magnitude for signed ops, raw value for unsigned ops).
  - Latch result sign and remainder sign.
  - Clear accumulator; counter = 0; busy = 1; div_by_zero = 0; state = RUN.
  - Exception: divide op with b == 0 goes to FIX instead, with the dz flag set.
- start = 1 while busy: ignored; latched operands are unchanged.
- start = 1 in DONE: accepted as a new start (back-to-back operation).
- RUN, one iteration per edge E1..E32:
  - Multiply: shift-add, one multiplier bit per cycle, LSB first, into a 64-bit accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Counter increments each cycle; after the 32nd iteration (E32), state = FIX.
- FIX, edge E33:
  - Apply signs: negate the 64-bit product if the signs differ; negate the quotient if the signs differ; remainder takes the dividend's sign.
  - Write lo/hi; done = 1; busy = 0; state = DONE.
  - Result: done is high in the cycle after E33, so latency from the start edge is 33 clocks.
- Divide-by-zero path:
  - E0 goes straight to FIX; at E1: lo = 32'hFFFFFFFF, hi = a (unmodified), div_by_zero = 1, done = 1.
- DONE:
  - done deasserts on the next edge; state = IDLE unless start is high.
  - lo, hi and div_by_zero hold until the next completed operation.
  - lo/hi never change while busy.
- Arithmetic rules:
  - All results are modulo 2^32 per half.
  - Signed DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps, no flag).
  - Signed MULT 0x80000000 * 0x80000000: hi = 0x40000000, lo = 0.
  - Zero operands still take the full 33 cycles (no early exit); the only short path is divide-by-zero.
- busy is combinationally equivalent to (state == RUN || state == FIX).

Test Plan:
- Reset, then MULTU a = 0xFFFFFFFF, b = 0xFFFFFFFF -> busy high for 33 cycles, done pulse exactly 1 cycle, hi = 0xFFFFFFFE, lo = 0x00000001.
- MULT a = -3, b = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. Then MULT 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0.
- DIV a = -7, b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU a = 100, b = 7 -> lo = 14, hi = 2. DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- DIVU a = 100, b = 0 -> done one cycle after start, div_by_zero = 1, lo = 0xFFFFFFFF, hi = 100. The next valid op clears div_by_zero.
- Start MULTU 5 * 6; pulse start with a = 9, b = 9 at cycle 10 -> ignored, result lo = 30, hi = 0. Assert start in the DONE cycle with DIVU 30 / 4 -> lo = 7, hi = 2 after a further 33 cycles.
- Start DIVU, drop reset at cycle 15 -> busy = 0, lo = hi = 0 immediately, no done pulse. Release reset and start MULTU 2 * 3 -> lo = 6.
